// File: rtl/dmem_pkg.sv
// Shared op encodings, arbiter state and lane helpers for the data-memory arbiter.
// Pure declarations: no logic, no latency.
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd4,
    LD_HU = 3'd5
  } ld_op_e;

  typedef enum logic [2:0] {
    ST_B = 3'd0,
    ST_H = 3'd1,
    ST_W = 3'd2
  } st_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int CNT_W  = 8;
  localparam int WCNT_W = 4;

  function automatic logic [31:0] st_repl(input logic [2:0] op, input logic [31:0] d);
    case (op)
      ST_B:    st_repl = {4{d[7:0]}};
      ST_H:    st_repl = {2{d[15:0]}};
      default: st_repl = d;
    endcase
  endfunction

  // Unknown store ops fall back to a full-word mask so the result stays deterministic.
  function automatic logic [3:0] st_mask(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      ST_B:    st_mask = 4'b0001 << lo;
      ST_H:    st_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: st_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      LD_B:    ld_ext = {{24{b[7]}}, b};
      LD_H:    ld_ext = {{16{h[15]}}, h};
      LD_BU:   ld_ext = {24'd0, b};
      LD_HU:   ld_ext = {16'd0, h};
      default: ld_ext = w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Store byte-lane replication/enables and load lane select/extension.
// Purely combinational, zero latency, no flow control.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  assign st_wdata = st_repl(st_op, st_data);
  assign st_be    = st_mask(st_op, st_lo);
  assign ld_data  = ld_ext(ld_op, ld_lo, ld_word);

endmodule

// File: rtl/dmem_arb.sv
// Single-port data SRAM arbiter: pipeline store > load > DMA, starved DMA forced first; read data one cycle after access.
// Losers are stalled combinationally; DMEM_ARB_WAIT_EN adds WAIT_CYC held wait cycles per access.
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int STARVE_LIM = 8,
  parameter int WAIT_CYC   = 0
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        p_rd_en,
  input  logic [31:0] p_rd_addr,
  input  logic [2:0]  p_rd_op,
  input  logic        p_wr_en,
  input  logic [31:0] p_wr_addr,
  input  logic [31:0] p_wr_data,
  input  logic [2:0]  p_wr_op,
  output logic        mem_stall,
  output logic        readram_stall,
  output logic [31:0] p_rdata,
  output logic        p_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic             free, starved, any, g_w, g_r, g_d;
  logic [CNT_W-1:0] starve_cnt;
  logic [2:0]       ld_op_q;
  logic [1:0]       ld_lo_q;
  logic [31:0]      st_wdata, ld_data;
  logic [3:0]       st_be;
  logic             acc_cs, acc_we, fin_p, fin_d;
  logic [29:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             unused_ok;

  // Outputs are gated by the reset input so they drop the moment reset asserts.
  assign starved = d_req && (starve_cnt == LIM);
  assign any     = cpurst_n && free;
  assign g_d     = any && d_req && (starved || (!p_wr_en && !p_rd_en));
  assign g_w     = any && p_wr_en && !starved;
  assign g_r     = any && p_rd_en && !p_wr_en && !starved;

  assign d_gnt         = g_d;
  assign mem_stall     = cpurst_n && p_wr_en && !g_w;
  assign readram_stall = cpurst_n && p_rd_en && !g_r;

  dmem_lane u_lane (
    .st_op   (p_wr_op),
    .st_lo   (p_wr_addr[1:0]),
    .st_data (p_wr_data),
    .st_wdata(st_wdata),
    .st_be   (st_be),
    .ld_op   (ld_op_q),
    .ld_lo   (ld_lo_q),
    .ld_word (ram_rdata),
    .ld_data (ld_data)
  );

  always_comb begin
    acc_cs    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_be    = '0;
    if (g_w) begin
      acc_cs    = 1'b1;
      acc_we    = 1'b1;
      acc_addr  = p_wr_addr[31:2];
      acc_wdata = st_wdata;
      acc_be    = st_be;
    end else if (g_r) begin
      acc_cs   = 1'b1;
      acc_addr = p_rd_addr[31:2];
      acc_be   = 4'b1111;
    end else if (g_d) begin
      acc_cs    = 1'b1;
      acc_we    = d_we;
      acc_addr  = d_addr[31:2];
      acc_wdata = d_wdata;
      acc_be    = 4'b1111;
    end
  end

`ifdef DMEM_ARB_WAIT_EN
  state_e            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              hold_we, pend_p, pend_d;
  logic [29:0]       hold_addr;
  logic [31:0]       hold_wdata;
  logic [3:0]        hold_be;
  logic              in_busy;

  assign free    = (state == IDLE);
  assign in_busy = cpurst_n && (state == BUSY);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: if (acc_cs && WAIT_CYC != 0) begin
        state_nxt = BUSY;
        wcnt_nxt  = WCNT_W'(WAIT_CYC);
      end
      BUSY: begin
        wcnt_nxt = wcnt - 1'b1;
        if (wcnt == WCNT_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
      pend_p     <= 1'b0;
      pend_d     <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (acc_cs) begin
        hold_we    <= acc_we;
        hold_addr  <= acc_addr;
        hold_wdata <= acc_wdata;
        hold_be    <= acc_be;
        pend_p     <= g_r;
        pend_d     <= g_d && !d_we;
      end
    end
  end

  assign ram_cs    = in_busy ? 1'b1       : acc_cs;
  assign ram_we    = in_busy ? hold_we    : acc_we;
  assign ram_addr  = in_busy ? hold_addr  : acc_addr;
  assign ram_wdata = in_busy ? hold_wdata : acc_wdata;
  assign ram_be    = in_busy ? hold_be    : acc_be;

  assign fin_p = (WAIT_CYC == 0) ? g_r : (state == BUSY && wcnt == WCNT_W'(1) && pend_p);
  assign fin_d = (WAIT_CYC == 0) ? (g_d && !d_we) : (state == BUSY && wcnt == WCNT_W'(1) && pend_d);
  assign unused_ok = ^d_addr[1:0];
`else
  assign free      = 1'b1;
  assign ram_cs    = acc_cs;
  assign ram_we    = acc_we;
  assign ram_addr  = acc_addr;
  assign ram_wdata = acc_wdata;
  assign ram_be    = acc_be;
  assign fin_p     = g_r;
  assign fin_d     = g_d && !d_we;
  assign unused_ok = ^{d_addr[1:0], 4'(WAIT_CYC)};
`endif

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      starve_cnt <= '0;
      ld_op_q    <= '0;
      ld_lo_q    <= '0;
      p_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      if (d_gnt) starve_cnt <= '0;
      else if (d_req && starve_cnt != LIM) starve_cnt <= starve_cnt + 1'b1;
      if (g_r) begin
        ld_op_q <= p_rd_op;
        ld_lo_q <= p_rd_addr[1:0];
      end
      p_rvalid <= fin_p;
      d_rvalid <= fin_d;
    end
  end

  // Read data is only presented while its valid pulse is high, so it reads 0 otherwise.
  assign p_rdata = p_rvalid ? ld_data : 32'd0;
  assign d_rdata = d_rvalid ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb in its default single-cycle build, with a behavioural SRAM.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        cpurst_n;
  logic        p_rd_en, p_wr_en, d_req, d_we;
  logic [31:0] p_rd_addr, p_wr_addr, p_wr_data, d_addr, d_wdata;
  logic [2:0]  p_rd_op, p_wr_op;
  logic        mem_stall, readram_stall, p_rvalid, d_gnt, d_rvalid;
  logic [31:0] p_rdata, d_rdata, ram_wdata, ram_rdata;
  logic        ram_cs, ram_we;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  wire         unused_tb = ^ram_addr[29:8];

  always #5 clk = ~clk;

  dmem_arb dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr), .p_rd_op(p_rd_op),
    .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data), .p_wr_op(p_wr_op),
    .mem_stall(mem_stall), .readram_stall(readram_stall),
    .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    p_rd_en = 0; p_wr_en = 0; d_req = 0; d_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    ram_rdata = 32'd0;
    cpurst_n = 0;
    idle_inputs();
    p_rd_addr = 0; p_rd_op = 0; p_wr_addr = 0; p_wr_data = 0; p_wr_op = 0;
    d_addr = 0; d_wdata = 0;

    // Reset: outputs forced low even with requests present
    @(negedge clk);
    p_wr_en = 1; p_rd_en = 1; d_req = 1;
    #1;
    check("rst_mem_stall", mem_stall, 0);
    check("rst_rd_stall", readram_stall, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_p_rvalid", p_rvalid, 0);
    check("rst_p_rdata", p_rdata, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    idle_inputs();
    @(negedge clk);
    cpurst_n = 1;

    // SW 0xDEADBEEF -> 0x100, then LW 0x100
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 32'h100; p_wr_data = 32'hDEADBEEF; p_wr_op = 3'd2;
    #1;
    check("sw_cs", ram_cs, 1);
    check("sw_we", ram_we, 1);
    check("sw_be", ram_be, 4'b1111);
    check("sw_addr", ram_addr, 30'h40);
    check("sw_wdata", ram_wdata, 32'hDEADBEEF);
    check("sw_stall", mem_stall, 0);
    @(negedge clk);
    p_wr_en = 0; p_rd_en = 1; p_rd_addr = 32'h100; p_rd_op = 3'd2;
    #1;
    check("lw_we", ram_we, 0);
    check("lw_stall", readram_stall, 0);
    @(negedge clk);
    p_rd_en = 0;
    #1;
    check("lw_rvalid", p_rvalid, 1);
    check("lw_rdata", p_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    check("lw_rvalid_pulse", p_rvalid, 0);

    // SB 0x80 -> 0x203, then LB and LBU back to back
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 32'h203; p_wr_data = 32'h12345680; p_wr_op = 3'd0;
    #1;
    check("sb_be", ram_be, 4'b1000);
    check("sb_wdata", ram_wdata, 32'h80808080);
    @(negedge clk);
    p_wr_en = 0; p_rd_en = 1; p_rd_addr = 32'h203; p_rd_op = 3'd0;
    @(negedge clk);
    p_rd_op = 3'd4;
    #1;
    check("lb_rdata", p_rdata, 32'hFFFFFF80);
    check("lbu_grant", readram_stall, 0);
    @(negedge clk);
    p_rd_en = 0;
    #1;
    check("lbu_rvalid", p_rvalid, 1);
    check("lbu_rdata", p_rdata, 32'h00000080);

    // SH 0x8001 -> 0x102 (word becomes 0x8001BEEF), LH 0x102, LHU 0x100
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 32'h102; p_wr_data = 32'h00008001; p_wr_op = 3'd1;
    #1;
    check("sh_be", ram_be, 4'b1100);
    check("sh_wdata", ram_wdata, 32'h80018001);
    @(negedge clk);
    p_wr_en = 0; p_rd_en = 1; p_rd_addr = 32'h102; p_rd_op = 3'd1;
    @(negedge clk);
    p_rd_addr = 32'h100; p_rd_op = 3'd5;
    #1;
    check("lh_rdata", p_rdata, 32'hFFFF8001);
    @(negedge clk);
    p_rd_en = 0;
    #1;
    check("lhu_rdata", p_rdata, 32'h0000BEEF);

    // Store and load requested together: store first, load next cycle
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 32'h104; p_wr_data = 32'h11223344; p_wr_op = 3'd2;
    p_rd_en = 1; p_rd_addr = 32'h100; p_rd_op = 3'd2;
    #1;
    check("both_we", ram_we, 1);
    check("both_rd_stall", readram_stall, 1);
    check("both_wr_stall", mem_stall, 0);
    @(negedge clk);
    p_wr_en = 0;
    #1;
    check("both2_rd_stall", readram_stall, 0);
    check("both2_wr_stall", mem_stall, 0);
    check("both2_addr", ram_addr, 30'h40);
    check("both2_we", ram_we, 0);
    @(negedge clk);
    p_rd_en = 0;
    #1;
    check("both_rdata", p_rdata, 32'h8001BEEF);

    // DMA starved by continuous loads: forced grant on 9th request cycle
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      d_req = 1; d_we = 0; d_addr = 32'h107;
      p_rd_en = 1; p_rd_addr = 32'h100; p_rd_op = 3'd2;
      #1;
      check($sformatf("starve_gnt_%0d", i), d_gnt, (i == 9));
      check($sformatf("starve_rdstall_%0d", i), readram_stall, (i == 9));
    end
    check("starve_addr", ram_addr, 30'h41);
    @(negedge clk);
    #1;
    check("starve_cleared", d_gnt, 0);
    check("starve_d_rvalid", d_rvalid, 1);
    check("starve_d_rdata", d_rdata, 32'h11223344);
    check("starve_no_prvalid", p_rvalid, 0);
    idle_inputs();

    // DMA write then read with an idle pipeline
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h108; d_wdata = 32'hCAFEF00D;
    #1;
    check("dwr_gnt", d_gnt, 1);
    check("dwr_be", ram_be, 4'b1111);
    check("dwr_addr", ram_addr, 30'h42);
    @(negedge clk);
    d_we = 0;
    #1;
    check("drd_gnt", d_gnt, 1);
    check("drd_we", ram_we, 0);
    @(negedge clk);
    d_req = 0;
    #1;
    check("drd_rdata", d_rdata, 32'hCAFEF00D);
    check("drd_no_prvalid", p_rvalid, 0);

    // Reset during a load grant cycle: access dropped, no rvalid
    @(negedge clk);
    p_rd_en = 1; p_rd_addr = 32'h100; p_rd_op = 3'd2;
    #1;
    check("rg_cs", ram_cs, 1);
    cpurst_n = 0;
    #1;
    check("rg_cs_rst", ram_cs, 0);
    check("rg_stall_rst", readram_stall, 0);
    @(negedge clk);
    p_rd_en = 0;
    cpurst_n = 1;
    #1;
    check("rg_no_rvalid", p_rvalid, 0);

    // Reset during the load response cycle
    @(negedge clk);
    p_rd_en = 1;
    @(negedge clk);
    p_rd_en = 0;
    #1;
    check("rr_rvalid", p_rvalid, 1);
    cpurst_n = 0;
    #1;
    check("rr_rvalid_rst", p_rvalid, 0);
    check("rr_rdata_rst", p_rdata, 0);
    @(negedge clk);
    cpurst_n = 1;
    @(negedge clk);
    #1;
    check("rr_after", p_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
